// File: rtl/muldiv_seq_pkg.sv
// Shared opcode space, FSM state encoding and opcode-class helpers for the
// iterative RV32M multiply/divide unit.
package muldiv_seq_pkg;

  localparam int XLEN_DEF = 32;

  // Combinational ALU opcodes
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd17;

  // M-extension opcodes handled by the sequential unit
  localparam logic [4:0] OP_MUL    = 5'd9;
  localparam logic [4:0] OP_MULH   = 5'd10;
  localparam logic [4:0] OP_MULHSU = 5'd11;
  localparam logic [4:0] OP_MULHU  = 5'd12;
  localparam logic [4:0] OP_DIV    = 5'd13;
  localparam logic [4:0] OP_DIVU   = 5'd14;
  localparam logic [4:0] OP_REM    = 5'd15;
  localparam logic [4:0] OP_REMU   = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_core.sv
// One radix-2 iteration (shift-add multiply or restoring divide step) and the
// two's-complement negator used for final sign correction.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              div_i,
  input  logic [XLEN-1:0]   hi_i,
  input  logic [XLEN-1:0]   lo_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   hi_o,
  output logic [XLEN-1:0]   lo_o,
  input  logic              neg_i,
  input  logic [2*XLEN-1:0] fix_i,
  output logic [2*XLEN-1:0] fix_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          qbit;

  always_comb begin
    sum     = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : '0)};
    // 33-bit partial remainder: running remainder with the next dividend bit
    shifted = {hi_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i};
    qbit    = ~diff[XLEN];
    if (div_i) begin
      hi_o = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], qbit};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

  assign fix_o = neg_i ? -fix_i : fix_i;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit with valid/ready issue and result ports.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a 33x33 multiplier.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rega,
  input  logic [XLEN-1:0] regb,
  input  logic [4:0]      md_opcode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_res,
  output logic            flag_zero,
  output logic            busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [4:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;

  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             op_dz, op_ovf;
  logic             spec_hit;
  logic [XLEN-1:0]  spec_res;

  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   fix_res;

  assign a_neg  = op_signed_a(md_opcode) && rega[XLEN-1];
  assign b_neg  = op_signed_b(md_opcode) && regb[XLEN-1];
  assign a_mag  = a_neg ? -rega : rega;
  assign b_mag  = b_neg ? -regb : regb;
  assign op_dz  = is_div_op(md_opcode) && (regb == '0);
  assign op_ovf = op_signed_b(md_opcode) && is_div_op(md_opcode)
                  && (rega == {1'b1, {(XLEN-1){1'b0}}}) && (regb == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fprod;
  logic [XLEN-1:0]          fast_res;

  assign fa       = {op_signed_a(md_opcode) & rega[XLEN-1], rega};
  assign fb       = {op_signed_b(md_opcode) & regb[XLEN-1], regb};
  assign fprod    = fa * fb;
  assign fast_res = (md_opcode == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif

  // Operations resolved on the accept edge without iterating
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    if (!is_md_op(md_opcode)) begin
      spec_res = '0;
    end else if (op_dz) begin
      spec_res = is_rem_op(md_opcode) ? rega : '1;
    end else if (op_ovf) begin
      spec_res = is_rem_op(md_opcode) ? '0 : rega;
`ifdef MULDIV_FAST_MUL_EN
    end else if (!is_div_op(md_opcode)) begin
      spec_res = fast_res;
`endif
    end else begin
      spec_hit = 1'b0;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .div_i (is_div_op(op_q)),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .b_i   (b_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo),
    .neg_i (neg_q),
    .fix_i (fix_in),
    .fix_o (fix_out)
  );

  // After CALC: hi_q:lo_q holds the product, or remainder:quotient for divides
  always_comb begin
    if (!is_div_op(op_q))   fix_in = {hi_q, lo_q};
    else if (is_rem_op(op_q)) fix_in = {{XLEN{1'b0}}, hi_q};
    else                    fix_in = {{XLEN{1'b0}}, lo_q};
    if ((op_q == OP_MUL) || is_div_op(op_q)) fix_res = fix_out[XLEN-1:0];
    else                                     fix_res = fix_out[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = md_opcode;
          cnt_d = CNT_W'(XLEN);
          neg_d = is_rem_op(md_opcode) ? a_neg : (a_neg ^ b_neg);
          if (spec_hit) begin
            res_d   = spec_res;
            zero_d  = (spec_res == '0);
            state_d = ST_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = a_mag;
            b_d     = b_mag;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        res_d   = fix_res;
        zero_d  = (fix_res == '0);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign md_res    = res_q;
  assign flag_zero = zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic model plus scoreboard compare on
// every cycle a result is presented.
module tb_muldiv_seq;

  localparam logic [4:0] MUL = 5'd9,  MULH = 5'd10, MULHSU = 5'd11, MULHU = 5'd12;
  localparam logic [4:0] DIV = 5'd13, DIVU = 5'd14, REM    = 5'd15, REMU  = 5'd16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rega = '0;
  logic [31:0] regb = '0;
  logic [4:0]  md_opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] md_res;
  logic        flag_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
    bit          seen;
  } exp_t;
  exp_t exp_q[$];

  muldiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rega      (rega),
    .regb      (regb),
    .md_opcode (md_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .md_res    (md_res),
    .flag_zero (flag_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          ub_s = longint'({32'b0, b});
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    logic [63:0]     q;
    bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MUL:    begin p = sa * sb;   return p[31:0];  end
      MULH:   begin p = sa * sb;   return p[63:32]; end
      MULHSU: begin p = sa * ub_s; return p[63:32]; end
      MULHU:  begin p = ua * ub;   return p[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU:   return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < MUL || op > REMU) return 1;
    if (op >= DIV) begin
      if (b == 0) return 1;
      if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 34;
`endif
  endfunction

  // Caller is positioned at a negedge; drives the request and waits for acceptance.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hand, input string name);
    exp_t e;
    int   n = 0;
    chk({name, "_model"}, model(op, a, b), hand);
    in_valid  = 1'b1;
    md_opcode = op;
    rega      = a;
    regb      = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL %s_accept_timeout in_ready=%b exp=1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    e.res = model(op, a, b); e.lat = lat_of(op, a, b);
    e.acc = cyc + 1; e.name = name; e.seen = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rega = $urandom;
    regb = $urandom;
    md_opcode = 5'($urandom_range(9, 16));
    $display("issued %s op=%0d a=%h b=%h exp=%h", name, op, a, b, e.res);
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hand, input string name);
    @(negedge clk);
    issue(op, a, b, hand, name);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !in_ready) begin
      errors++;
      $display("FAIL %s_drain_timeout pending=%0d exp=0", name, exp_q.size());
    end
  endtask

  // Scoreboard compare: every cycle a result is presented
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid md_res=%h exp=none", md_res);
      end else begin
        chk({exp_q[0].name, "_res"}, md_res, exp_q[0].res);
        chk({exp_q[0].name, "_zero"}, {31'b0, flag_zero}, {31'b0, exp_q[0].res == 32'h0});
        if (!exp_q[0].seen) begin
          exp_q[0].seen = 1'b1;
          chk({exp_q[0].name, "_lat"}, cyc - exp_q[0].acc + 1, exp_q[0].lat);
        end
        if (out_ready) begin
          $display("retired %s md_res=%h zero=%b", exp_q[0].name, md_res, flag_zero);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_md_res", md_res, 32'h0);
    chk("rst_flag_zero", {31'b0, flag_zero}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;

    run(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    run(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
    run(MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         "mulh_ff");
    run(MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "mulhsu_m1_2");
    run(MULHU,  32'h8000_0000,  32'd2,         32'd1,         "mulhu_2p31x2");
    run(MUL,    32'h8000_0000,  32'd2,         32'h0,         "mul_2p31x2");
    run(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
    run(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    run(DIVU,   32'd100,        32'd7,         32'd14,        "divu_100_7");
    run(REMU,   32'd100,        32'd7,         32'd2,         "remu_100_7");
    run(DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, "divu_max_1");
    run(REMU,   32'd7,          32'd9,         32'd7,         "remu_7_9");
    run(DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, "div_5_0");
    run(REM,    32'd5,          32'd0,         32'd5,         "rem_5_0");
    run(DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu_5_0");
    run(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "rem_ovf");
    run(5'd3,   32'd12,         32'd34,        32'h0,         "undef_op");
    wait_drain("directed");

    // Backpressure: result held for 10 cycles while a second request waits
    @(posedge clk); #1 out_ready = 1'b0;
    run(DIVU, 32'd100, 32'd7, 32'd14, "bp_divu");
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    in_valid = 1'b1; md_opcode = REMU; rega = 32'd100; regb = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_busy", {31'b0, busy}, 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_overlap", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp_ready_after", {31'b0, in_ready}, 32'd1);
    issue(REMU, 32'd100, 32'd7, 32'd2, "bp_remu");
    wait_drain("backpressure");

    // Reset mid-CALC aborts the operation
    run(DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, "abort_divu");
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_md_res", md_res, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "post_abort_div");
    run(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "post_abort_mulhu");
    wait_drain("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
